// File: rtl/store_pkg.sv
// Shared types and lane helpers for the store lane packer.
// Size codes, FSM states, byte-enable and replication functions.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    READ,
    WAIT,
    WRITE
  } state_t;

  // Lanes touched by a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_be(
    input logic [1:0] size,
    input logic [1:0] off,
    input logic       big
  );
    logic [3:0] b;
    case (size)
      SZ_BYTE: b = 4'b0001 << off;
      SZ_HALF: b = off[1] ? 4'b1100 : 4'b0011;
      default: b = 4'b1111;
    endcase
    return big ? {b[0], b[1], b[2], b[3]} : b;
  endfunction

  // Narrow data copied into every lane it could occupy.
  function automatic logic [31:0] replicate(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{data[7:0]}};
      SZ_HALF: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: replaces selected lanes of an old word.
// Produces the merged word and the lane byte enables.
module store_lane_merge
  import store_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged,
  output logic [3:0]  be
);

  logic [31:0] rep;

  // Selected lanes take the replicated data, the rest keep the old word.
  always_comb begin
    be  = lane_be(size, offset, BIG_ENDIAN != 0);
    rep = replicate(size, data);
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_lane_packer.sv
// Narrows register data into byte/half/word stores to word memory.
// STORE_BYTE_ENABLE_EN: use byte enables instead of read-modify-write.
module store_lane_packer
  import store_pkg::*;
#(
  parameter int AW         = 10,
  parameter int BIG_ENDIAN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_data,
  input  logic [1:0]    req_size,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wr_en,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be
);

  state_t state, next;

  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic [31:0]   data_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [3:0]    lanes;
  logic          bad;
  logic          direct;
  logic          accept;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // Alignment check and path selection for the request at the port.
  always_comb begin
    bad = (req_size == 2'b11)
        | ((req_size == SZ_HALF) & req_addr[0])
        | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
`ifdef STORE_BYTE_ENABLE_EN
    direct = 1'b1;
`else
    direct = (req_size == SZ_WORD);
`endif
    accept = req_valid & (state == IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Latch the request; the word address only moves on a good accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q  <= '0;
      size_q <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else if (accept) begin
      off_q  <= req_addr[1:0];
      size_q <= req_size;
      data_q <= req_data;
      if (!bad) addr_q <= req_addr[AW+1:2];
    end
  end

`ifdef STORE_BYTE_ENABLE_EN
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign old_word = replicate(size_q, data_q);
`else
  logic [31:0] old_q;
  logic        unused_lanes;
  assign unused_lanes = ^lanes;

  // Capture the memory word returned for the read-modify-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                old_q <= '0;
    else if (state == WAIT) old_q <= mem_rdata;
  end

  assign old_word = old_q;
`endif

  store_lane_merge #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_merge (
    .old_word(old_word),
    .data    (data_q),
    .size    (size_q),
    .offset  (off_q),
    .merged  (merged),
    .be      (lanes)
  );

  // Next-state logic.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            bad:            next = ERR;
            (!bad & direct): next = WRITE;
            default:        next = READ;
          endcase
        end
      end
      READ:    next = WAIT;
      WAIT:    next = WRITE;
      WRITE:   next = IDLE;
      ERR:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready = (state == IDLE);
    done      = (state == WRITE);
    err       = (state == ERR);
    mem_wr_en = (state == WRITE);
    mem_addr  = addr_q;
    mem_wdata = '0;
    mem_be    = '0;
`ifdef STORE_BYTE_ENABLE_EN
    mem_rd_en = 1'b0;
    if (state == WRITE) begin
      mem_wdata = merged;
      mem_be    = lanes;
    end
`else
    mem_rd_en = (state == READ);
    if (state == WRITE) begin
      mem_wdata = merged;
      mem_be    = 4'hF;
    end
`endif
  end

endmodule

// File: tb/tb_store_lane_packer.sv
// Randomized scoreboard bench for store_lane_packer.
// Reference model stores bytes in a byte-addressed array.
module tb_store_lane_packer;

  localparam int AW  = 10;
  localparam int BIG = 0;
  localparam int NW  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic [1:0]    req_size;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [31:0]   mem_rdata = '0;
  logic          mem_wr_en;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  typedef struct {
    bit            is_err;
    int            lat;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  bit prev_end = 0;

  logic [31:0] pm [0:NW-1];
  logic [7:0]  rb [0:4*NW-1];
  logic [31:0] nw;

  always #5 clk = ~clk;

  store_lane_packer #(
    .AW(AW),
    .BIG_ENDIAN(BIG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_size (req_size),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be)
  );

  // Synchronous memory with byte enables.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      nw = pm[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
      pm[mem_addr] <= nw;
    end
    if (mem_rd_en) mem_rdata <= pm[mem_addr];
  end

  // Cycle counter and handshake timestamp.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) acc <= cyc;
  end

  function automatic int lanepos(input int k);
    return (BIG != 0) ? 3 - k : k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    pm[w] = v;
    for (int k = 0; k < 4; k++) rb[4*w + k] = v[8*lanepos(k) +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[8*lanepos(k) +: 8] = rb[4*w + k];
    return r;
  endfunction

  // Reference: store bytes in memory order, then view the word.
  task automatic model(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, output exp_t e);
    int ba;
    int n;
    logic [7:0] v;
    ba = int'(a[AW+1:0]);
    e.is_err = 0;
    e.lat = 1;
    e.addr = '0;
    e.wdata = '0;
    e.be = '0;
    if (s == 2'b11 || (s == 2'b01 && ba % 2 != 0) ||
        (s == 2'b10 && ba % 4 != 0)) begin
      e.is_err = 1;
      return;
    end
    n = 1 << s;
    for (int i = 0; i < n; i++) begin
      v = (BIG != 0) ? d[8*(n-1-i) +: 8] : d[8*i +: 8];
      rb[ba + i] = v;
      e.be[lanepos((ba + i) % 4)] = 1'b1;
    end
    e.addr = AW'(ba / 4);
`ifdef STORE_BYTE_ENABLE_EN
    if (s == 2'b00)      e.wdata = {4{d[7:0]}};
    else if (s == 2'b01) e.wdata = {2{d[15:0]}};
    else                 e.wdata = d;
`else
    e.lat = (s == 2'b10) ? 1 : 3;
    e.wdata = ref_word(ba / 4);
    e.be = 4'hF;
`endif
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    exp_t e;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    req_size = s;
    model(a, d, s, e);
    @(posedge clk);
    q.push_back(e);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_data = $urandom;
    req_size = 2'($urandom);
  endtask

  // Start a byte store and pull reset before its write is issued.
  task automatic abort_store();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_addr = 32'h14;
    req_data = 32'h0000_0077;
    req_size = 2'b00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`ifndef STORE_BYTE_ENABLE_EN
    @(posedge clk);
    #1;
`endif
    rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_be", 32'(mem_be), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT writes or flags an error.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_end = 0;
    end else begin
      chk("rd_wr_excl", 32'(mem_rd_en & mem_wr_en), 0);
`ifdef STORE_BYTE_ENABLE_EN
      chk("rd_tied", 32'(mem_rd_en), 0);
`endif
      if (prev_end) chk("ready_after", 32'(req_ready), 1);
      prev_end = done | err;
      if (mem_wr_en || err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected: got wr=%b err=%b expected none",
                   mem_wr_en, err);
        end else begin
          e = q.pop_front();
          chk("is_err", 32'(err), 32'(e.is_err));
          chk("done", 32'(done), 32'(!e.is_err));
          chk("latency", 32'(cyc - acc), 32'(e.lat));
          if (!e.is_err) begin
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("mem_be", 32'(mem_be), 32'(e.be));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_size = '0;
    for (int w = 0; w < NW; w++) set_word(w, $urandom);
    set_word(4, 32'h1122_3344);
    set_word(0, 32'hAAAA_BBBB);
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 1);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_wr", 32'(mem_wr_en), 0);
    chk("reset_rd", 32'(mem_rd_en), 0);
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_be", 32'(mem_be), 0);
    rst = 1'b0;

    issue(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
    issue(32'h0000_0012, 32'hFFFF_FFAB, 2'b00);
    issue(32'h0000_0002, 32'h0000_1234, 2'b01);
    issue(32'h0000_0003, 32'h0000_5678, 2'b01);
    issue(32'h0000_0000, 32'h0000_9999, 2'b11);
    issue(32'h0000_0005, 32'h0000_00CD, 2'b00);
    issue(32'hFFFF_F01E, 32'hABCD_1357, 2'b01);

    abort_store();
    issue(32'h0000_0020, 32'hCAFE_F00D, 2'b10);

    for (int i = 0; i < 300; i++)
      issue(32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)));

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drained", 32'(q.size()), 0);
    for (int w = 0; w < 17; w++) chk("mem_image", pm[w], ref_word(w));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
